// File: rtl/matmul_sequencer.sv
// matmul_sequencer: 3x3 x 3x3 unsigned 8-bit matrix multiply (C = A x B, modulo 256),
// computed on one shared multiply-accumulate over 27 cycles.
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   clear               - synchronous job abort (active-high)
//   in_valid/in_ready   - operand byte stream: A row-major, then B row-major (18 bytes)
//   in_data[7:0]        - operand byte
//   out_valid/out_ready - result stream: C row-major (9 bytes)
//   out_data[7:0]       - result element, low 8 bits
//   busy                - high while computing
//   ovf                 - sticky: some element of the current job exceeded 255
module matmul_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic       busy,
    output logic       ovf
);
    localparam int unsigned DW     = 8;
    localparam int unsigned ACC_W  = 18;
    localparam int unsigned N_EL   = 9;
    localparam int unsigned N_LOAD = 18;

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_e;

    state_e             state_q, state_d;
    logic [4:0]         load_cnt_q, load_cnt_d;
    logic [1:0]         i_q, i_d, j_q, j_d, k_q, k_d;
    logic [3:0]         out_idx_q, out_idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [DW-1:0]      a_q [N_EL], a_d [N_EL];
    logic [DW-1:0]      b_q [N_EL], b_d [N_EL];
    logic [DW-1:0]      c_q [N_EL], c_d [N_EL];
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic               busy_q, busy_d;

    // Shared MAC datapath: A[i][k] * B[k][j], accumulator restarts at k=0
    logic [3:0]         a_idx, b_idx, c_idx, load_idx;
    logic [2*DW-1:0]    prod;
    logic [ACC_W-1:0]   acc_next;

    assign a_idx    = 4'(i_q) * 4'd3 + 4'(k_q);
    assign b_idx    = 4'(k_q) * 4'd3 + 4'(j_q);
    assign c_idx    = 4'(i_q) * 4'd3 + 4'(j_q);
    assign prod     = 16'(a_q[a_idx]) * 16'(b_q[b_idx]);
    assign acc_next = ((k_q == 2'd0) ? '0 : acc_q) + ACC_W'(prod);
    assign load_idx = (load_cnt_q < 5'd9) ? 4'(load_cnt_q) : 4'(load_cnt_q - 5'd9);

    // Next-state, datapath updates and registered-output values
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        out_idx_d  = out_idx_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;

        if (clear) begin
            // Abort wins over any same-cycle handshake; ovf and storage are kept
            state_d    = S_LOAD;
            load_cnt_d = '0;
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
            out_idx_d  = '0;
            acc_d      = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        if (load_cnt_q < 5'd9) a_d[load_idx] = in_data;
                        else                   b_d[load_idx] = in_data;
                        if (load_cnt_q == 5'(N_LOAD - 1)) begin
                            load_cnt_d = '0;
                            i_d        = '0;
                            j_d        = '0;
                            k_d        = '0;
                            acc_d      = '0;
                            ovf_d      = 1'b0;
                            state_d    = S_COMPUTE;
                        end else begin
                            load_cnt_d = load_cnt_q + 5'd1;
                        end
                    end
                end
                S_COMPUTE: begin
                    acc_d = acc_next;
                    if (k_q == 2'd2) begin
                        c_d[c_idx] = acc_next[DW-1:0];
                        if (acc_next > ACC_W'(255)) ovf_d = 1'b1;
                        k_d = '0;
                        if (j_q == 2'd2) begin
                            j_d = '0;
                            if (i_q == 2'd2) begin
                                i_d       = '0;
                                out_idx_d = '0;
                                state_d   = S_UNLOAD;
                            end else begin
                                i_d = i_q + 2'd1;
                            end
                        end else begin
                            j_d = j_q + 2'd1;
                        end
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
                S_UNLOAD: begin
                    if (out_ready) begin
                        if (out_idx_q == 4'(N_EL - 1)) begin
                            out_idx_d = '0;
                            state_d   = S_LOAD;
                        end else begin
                            out_idx_d = out_idx_q + 4'd1;
                        end
                    end
                end
                default: state_d = S_LOAD;
            endcase
        end

        // Outputs are registered from the next state so they line up with state_q
        in_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d == S_COMPUTE);
        out_valid_d = (state_d == S_UNLOAD);
        out_data_d  = out_valid_d ? c_d[out_idx_d] : '0;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            load_cnt_q  <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            out_idx_q   <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            for (int n = 0; n < int'(N_EL); n++) begin
                a_q[n] <= '0;
                b_q[n] <= '0;
                c_q[n] <= '0;
            end
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            out_idx_q   <= out_idx_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed self-checking bench for matmul_sequencer.
// Jobs are loaded as 18-byte streams; results are compared with hand-computed matrices.
module tb_matmul_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       ovf;

    int checks = 0;
    int passes = 0;

    logic [7:0] job [18];
    logic [7:0] exp [9];

    matmul_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
    endtask

    // Advance one clock; sample/drive 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_job(input string tag, input logic [7:0] d [18]);
        for (int n = 0; n < 18; n++) begin
            in_valid = 1'b1;
            in_data  = d[n];
            if (n == 0) check($sformatf("%s in_ready at load", tag), 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Counts busy cycles (bounded), then checks the COMPUTE->UNLOAD handover
    task automatic run_compute(input string tag, input logic exp_ovf);
        int cnt;
        cnt = 0;
        check($sformatf("%s ovf at compute entry", tag), 32'(ovf), 32'd0);
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
        check($sformatf("%s busy cycles", tag), 32'(cnt), 32'd27);
        check($sformatf("%s out_valid after compute", tag), 32'(out_valid), 32'd1);
        check($sformatf("%s in_ready in unload", tag), 32'(in_ready), 32'd0);
        check($sformatf("%s ovf", tag), 32'(ovf), 32'(exp_ovf));
    endtask

    task automatic unload_job(input string tag, input logic [7:0] e [9]);
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            check($sformatf("%s out_valid[%0d]", tag, n), 32'(out_valid), 32'd1);
            check($sformatf("%s C[%0d]", tag, n), 32'(out_data), 32'(e[n]));
            step();
        end
        out_ready = 1'b0;
        check($sformatf("%s out_valid after C22", tag), 32'(out_valid), 32'd0);
        check($sformatf("%s in_ready after C22", tag), 32'(in_ready), 32'd1);
    endtask

    initial begin
        int idx;
        int guard;
        logic r;

        // Reset state
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic: A all 2, B all 3 -> every element 18
        for (int n = 0; n < 18; n++) job[n] = (n < 9) ? 8'd2 : 8'd3;
        for (int n = 0; n < 9; n++) exp[n] = 8'h12;
        load_job("basic", job);
        run_compute("basic", 1'b0);
        unload_job("basic", exp);

        // Overflow: row 0 = 4000 mod 256 = 0xA0, rows 1-2 = 3840 mod 256 = 0
        for (int n = 0; n < 18; n++) job[n] = (n < 9) ? 8'h20 : 8'h28;
        job[0] = 8'h24;
        for (int n = 0; n < 9; n++) exp[n] = (n < 3) ? 8'hA0 : 8'h00;
        load_job("ovf", job);
        run_compute("ovf", 1'b1);
        unload_job("ovf", exp);
        check("ovf held in load", 32'(ovf), 32'd1);

        // All ones: ovf clears at COMPUTE entry, each element 3
        for (int n = 0; n < 18; n++) job[n] = 8'd1;
        for (int n = 0; n < 9; n++) exp[n] = 8'd3;
        load_job("ones", job);
        run_compute("ones", 1'b0);
        unload_job("ones", exp);

        // Extreme: 3*255*255 = 195075, low byte 3
        for (int n = 0; n < 18; n++) job[n] = 8'hFF;
        for (int n = 0; n < 9; n++) exp[n] = 8'h03;
        load_job("ff", job);
        run_compute("ff", 1'b1);
        unload_job("ff", exp);

        // Clear after 5 bytes, with a simultaneous offered byte that must be dropped
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            in_data  = 8'h77;
            step();
        end
        clear    = 1'b1;
        in_data  = 8'h55;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clear in_ready", 32'(in_ready), 32'd1);
        check("clear busy", 32'(busy), 32'd0);
        check("clear out_valid", 32'(out_valid), 32'd0);
        check("clear keeps ovf", 32'(ovf), 32'd1);

        // Identity x (1..9) with backpressure; distinct values expose loss/duplication
        for (int n = 0; n < 9; n++) job[n] = (n == 0 || n == 4 || n == 8) ? 8'd1 : 8'd0;
        for (int n = 0; n < 9; n++) job[9 + n] = 8'(n + 1);
        for (int n = 0; n < 9; n++) exp[n] = 8'(n + 1);
        load_job("ident", job);
        run_compute("ident", 1'b0);
        for (int n = 0; n < 5; n++) begin
            check($sformatf("stall valid %0d", n), 32'(out_valid), 32'd1);
            check($sformatf("stall C00 %0d", n), 32'(out_data), 32'(exp[0]));
            step();
        end
        idx   = 0;
        guard = 0;
        r     = 1'b1;
        while (idx < 9 && guard < 40) begin
            out_ready = r;
            check($sformatf("bp valid g%0d", guard), 32'(out_valid), 32'd1);
            check($sformatf("bp C[%0d] g%0d", idx, guard), 32'(out_data), 32'(exp[idx]));
            step();
            if (r) idx++;
            r = ~r;
            guard++;
        end
        out_ready = 1'b0;
        check("bp elements taken", 32'(idx), 32'd9);
        check("bp out_valid after C22", 32'(out_valid), 32'd0);

        // Asynchronous reset at COMPUTE cycle 10 abandons the job
        for (int n = 0; n < 18; n++) job[n] = 8'hFF;
        load_job("rst job", job);
        repeat (10) step();
        check("busy before reset", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset in_ready", 32'(in_ready), 32'd1);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset out_data", 32'(out_data), 32'd0);
        check("async reset ovf", 32'(ovf), 32'd0);
        #2;
        rst_n = 1'b1;
        step();

        // Fresh job after reset
        for (int n = 0; n < 18; n++) job[n] = (n < 9) ? 8'd2 : 8'd3;
        for (int n = 0; n < 9; n++) exp[n] = 8'h12;
        load_job("post-reset", job);
        run_compute("post-reset", 1'b0);
        unload_job("post-reset", exp);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset: clk, input, 1, rising-edge system clock.
REQ-002 Reset, input, 1, SHALL be asynchronous, active-low (0 = reset asserted).
REQ-003 Clear, input, 1, SHALL be a synchronous job abort, active-high.
REQ-004 in_valid, input, 1, SHALL mean the producer offers in_data.
REQ-005 in_data, input, 8, SHALL be an unsigned operand byte.
REQ-006 in_ready, output, 1, SHALL mean the block accepts in_data this cycle.
REQ-007 out_valid, output, 1, SHALL mean out_data holds a result element.
REQ-008 out_data, output, 8, SHALL be the result element, modulo 256.
REQ-009 out_ready, input, 1, SHALL mean the consumer takes out_data this cycle.
REQ-010 busy, output, 1, SHALL be high only in COMPUTE.
REQ-011 ovf, output, 1, SHALL be a sticky flag: some element of the current job exceeded 255.

Function
REQ-012 Computation SHALL be C = A x B for 3x3 matrices of 8-bit unsigned elements, using one shared multiply-accumulate sequenced over time.
REQ-013 The FSM SHALL have exactly three states: LOAD, COMPUTE and UNLOAD.
REQ-014 In LOAD, in_ready SHALL be 1; a byte is accepted on each edge where in_valid&in_ready; the load count runs 0..17.
REQ-015 Load order SHALL be A row-major (A00,A01,...,A22), then B row-major (B00,...,B22).
REQ-016 On the edge accepting byte 18, the FSM SHALL go LOAD->COMPUTE and the load count SHALL reset to 0.
REQ-017 COMPUTE SHALL last exactly 27 cycles, with loop order i (row), j (column), k (inner), k fastest; each cycle acc += A[i][k]*B[k][j].
REQ-018 acc SHALL be 18 bits wide, with no internal overflow (max 195075); acc SHALL clear at k=0 of each element.
REQ-019 At k=2, C[i][j] SHALL be written as acc_next[7:0].
REQ-020 When acc_next > 255 at that write, ovf SHALL be set.
REQ-021 After the 27th COMPUTE cycle the FSM SHALL go COMPUTE->UNLOAD; out_valid SHALL first be high in the cycle following the 27th COMPUTE cycle.
REQ-022 In UNLOAD, out_valid SHALL be 1, and out_data SHALL be C in row-major order (C00 first); the index advances on out_valid&out_ready.
REQ-023 While out_ready=0, out_data and out_valid SHALL hold stable.
REQ-024 On the handshake of C22, the FSM SHALL go UNLOAD->LOAD, and out_valid SHALL be 0 in the next cycle.
REQ-025 in_ready SHALL be 0 in COMPUTE and UNLOAD; in_valid SHALL be ignored there.
REQ-026 out_valid SHALL be 0 in LOAD and COMPUTE.
REQ-027 ovf SHALL clear on the LOAD->COMPUTE transition and hold through UNLOAD until the next job's COMPUTE entry.
REQ-028 Clear=1 in any state SHALL, at the next edge, force LOAD with all counters at 0 and acc = 0; ovf SHALL be unchanged.
REQ-029 Clear SHALL take priority over a simultaneous in or out handshake; that handshake SHALL be discarded.
REQ-030 A/B/C storage SHALL not be cleared by Clear; stale values SHALL be fully overwritten by the next job.

Reset
REQ-031 When Reset=0, the block SHALL immediately (asynchronously) force state=LOAD, all counters=0, acc=0 and ovf=0.
REQ-032 While Reset=0, outputs SHALL be in_ready=1, out_valid=0, out_data=0 and busy=0.
REQ-033 A/B/C storage SHALL reset to 0.
REQ-034 Reset assertion mid-COMPUTE or mid-UNLOAD SHALL abandon the job; after release, the block SHALL accept a fresh 18-byte load.

Verification
REQ-035 Basic: A all 2, B all 3, out_ready=1 -> busy high for 27 cycles; outputs nine values of 18 (0x12); ovf=0.
REQ-036 Identity: A=I, B=1..9 row-major -> output 1,2,...,9; ovf=0.
REQ-037 Overflow: A00=0x24, all other A=0x20, B all 0x28 -> row 0 gives 0xA0 (4000 mod 256), rows 1-2 give 0x00 (3840 mod 256); ovf=1. Then a second job with all 1s -> ovf clears at COMPUTE entry; output all 3.
REQ-038 Saturation extreme: A and B all 0xFF -> output all 0x03 (195075 mod 256); ovf=1.
REQ-039 Backpressure: out_ready held 0 for 5 cycles at C00, then toggled every cycle -> no element lost or duplicated; out_data stable while stalled.
REQ-040 Abort: Clear after 5 bytes; Reset=0 asserted at COMPUTE cycle 10 -> both return to LOAD with count 0; a subsequent full load produces correct results.
